// File: rtl/wasm_cpu_if.sv
// Fetch bus between wasm_cpu (master) and a wide-fetch byte ROM (slave).
interface wasm_cpu_if #(
  parameter int unsigned MEM_DEPTH = 4
);
  logic [MEM_DEPTH:0] mem_addr;
  logic [3:0]         mem_extra;
  logic [127:0]       mem_data;
  logic               mem_error;

  modport master (output mem_addr, output mem_extra, input mem_data, input mem_error);
  modport slave  (input mem_addr, input mem_extra, output mem_data, output mem_error);
endinterface

// File: rtl/wasm_cpu.sv
// wasm_cpu: two-cycle (FETCH/EXEC) WebAssembly stack-machine core, integer/const subset.
// Optional macro WASM_CPU_TYPECHECK_EN: binary ops trap TYPE_MISMATCH on operand type mismatch.
module wasm_cpu #(
  parameter int unsigned HAS_FPU   = 1,
  parameter int unsigned USE_64B   = 1,
  parameter int unsigned MEM_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  wasm_cpu_if.master  mem,
  output logic [63:0] result,
  output logic [1:0]  result_type,
  output logic        result_empty,
  output logic [3:0]  trap
);
  localparam int unsigned PCW = MEM_DEPTH + 1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] TRAP_NONE          = 4'd0;
  localparam logic [3:0] TRAP_UNREACHABLE   = 4'd1;
  localparam logic [3:0] TRAP_BAD_OPCODE    = 4'd2;
  localparam logic [3:0] TRAP_UNDERFLOW     = 4'd3;
  localparam logic [3:0] TRAP_OVERFLOW      = 4'd4;
  localparam logic [3:0] TRAP_NO_64B        = 4'd5;
  localparam logic [3:0] TRAP_MEM_ERROR     = 4'd6;
  localparam logic [3:0] TRAP_TYPE_MISMATCH = 4'd7;
  localparam logic [3:0] TRAP_NO_FPU        = 4'd8;

  localparam logic [1:0] TY_I32 = 2'd0;
  localparam logic [1:0] TY_I64 = 2'd1;
  localparam logic [1:0] TY_F32 = 2'd2;
  localparam logic [1:0] TY_F64 = 2'd3;

  typedef struct packed {
    logic        ok;
    logic [3:0]  len;
    logic [63:0] value;
  } leb_t;

  // Signed LEB128: 7-bit groups little-endian, sign taken from bit 6 of the last byte.
  function automatic leb_t leb_decode(input logic [79:0] bytes, input logic is64);
    leb_t       r;
    logic [69:0] acc;
    logic       sign;
    logic       done;
    logic [3:0] maxlen;
    r      = '0;
    acc    = '0;
    sign   = 1'b0;
    done   = 1'b0;
    maxlen = is64 ? 4'd10 : 4'd5;
    for (int i = 0; i < 10; i++) begin
      if (!done && (4'(i) < maxlen)) begin
        acc[7*i +: 7] = bytes[8*i +: 7];
        if (!bytes[8*i+7]) begin
          done  = 1'b1;
          r.len = 4'(i + 1);
          sign  = bytes[8*i+6];
        end else begin
          done = 1'b0;
        end
      end
    end
    for (int j = 0; j < 70; j++) begin
      if (done && (j >= 7 * int'(r.len))) begin
        acc[j] = sign;
      end
    end
    r.ok    = done;
    r.value = is64 ? acc[63:0] : {32'd0, acc[31:0]};
    return r;
  endfunction

  state_t      state_r;
  logic [PCW-1:0] pc_r;
  logic [3:0]  mem_extra_r;
  logic [3:0]  depth_r;
  logic [63:0] stack_val_r  [8];
  logic [1:0]  stack_type_r [8];
  logic [63:0] result_r;
  logic [1:0]  result_type_r;
  logic        result_empty_r;
  logic [3:0]  trap_r;

  logic [7:0]  op_s;
  leb_t        leb_s;
  logic [2:0]  top_idx_s;
  logic [2:0]  sec_idx_s;
  logic [2:0]  wr_idx_s;
  logic [63:0] a_val_s;
  logic [63:0] b_val_s;
  logic        op64_s;
  logic        opsub_s;
  logic [1:0]  bin_type_s;
  logic        type_bad_s;
  logic [31:0] arith32_s;
  logic [63:0] arith_s;
  logic        full_s;
  logic [3:0]  exec_trap_s;
  logic        exec_end_s;
  logic        do_push_s;
  logic [63:0] push_val_s;
  logic [1:0]  push_type_s;
  logic [3:0]  depth_next_s;
  logic [3:0]  pc_step_s;
  logic        unused_hi_s;

  assign unused_hi_s   = ^mem.mem_data[127:88];
  assign mem.mem_addr  = pc_r;
  assign mem.mem_extra = mem_extra_r;
  assign result        = result_r;
  assign result_type   = result_type_r;
  assign result_empty  = result_empty_r;
  assign trap          = trap_r;

  // Decode the fetched window and work out the trap, stack update and pc step.
  always_comb begin
    op_s       = mem.mem_data[7:0];
    leb_s      = leb_decode(mem.mem_data[87:8], op_s == 8'h42);
    top_idx_s  = depth_r[2:0] - 3'd1;
    sec_idx_s  = depth_r[2:0] - 3'd2;
    a_val_s    = stack_val_r[sec_idx_s];
    b_val_s    = stack_val_r[top_idx_s];
    op64_s     = (op_s == 8'h7C) || (op_s == 8'h7D);
    opsub_s    = (op_s == 8'h6B) || (op_s == 8'h7D);
    bin_type_s = op64_s ? TY_I64 : TY_I32;
`ifdef WASM_CPU_TYPECHECK_EN
    type_bad_s = (stack_type_r[sec_idx_s] != bin_type_s) ||
                 (stack_type_r[top_idx_s] != bin_type_s);
`else
    type_bad_s = 1'b0;
`endif
    arith32_s = opsub_s ? (a_val_s[31:0] - b_val_s[31:0]) : (a_val_s[31:0] + b_val_s[31:0]);
    if (op64_s) begin
      arith_s = opsub_s ? (a_val_s - b_val_s) : (a_val_s + b_val_s);
    end else begin
      arith_s = {32'd0, arith32_s};
    end
    full_s       = (depth_r == 4'd8);
    exec_trap_s  = TRAP_NONE;
    exec_end_s   = 1'b0;
    do_push_s    = 1'b0;
    push_val_s   = 64'd0;
    push_type_s  = TY_I32;
    depth_next_s = depth_r;
    wr_idx_s     = depth_r[2:0];
    pc_step_s    = 4'd1;
    if (mem.mem_error) begin
      exec_trap_s = TRAP_MEM_ERROR;
    end else begin
      case (op_s)
        8'h00: exec_trap_s = TRAP_UNREACHABLE;
        8'h01: pc_step_s = 4'd1;
        8'h0B: exec_end_s = 1'b1;
        8'h1A: begin
          if (depth_r == 4'd0) begin
            exec_trap_s = TRAP_UNDERFLOW;
          end else begin
            depth_next_s = depth_r - 4'd1;
          end
        end
        8'h41, 8'h42: begin
          if ((op_s == 8'h42) && (USE_64B == 32'd0)) begin
            exec_trap_s = TRAP_NO_64B;
          end else if (!leb_s.ok) begin
            exec_trap_s = TRAP_BAD_OPCODE;
          end else if (full_s) begin
            exec_trap_s = TRAP_OVERFLOW;
          end else begin
            do_push_s    = 1'b1;
            push_val_s   = leb_s.value;
            push_type_s  = (op_s == 8'h42) ? TY_I64 : TY_I32;
            depth_next_s = depth_r + 4'd1;
            pc_step_s    = leb_s.len + 4'd1;
          end
        end
        8'h43, 8'h44: begin
          if (HAS_FPU == 32'd0) begin
            exec_trap_s = TRAP_NO_FPU;
          end else if (full_s) begin
            exec_trap_s = TRAP_OVERFLOW;
          end else begin
            do_push_s    = 1'b1;
            depth_next_s = depth_r + 4'd1;
            if (op_s == 8'h43) begin
              push_val_s  = {32'd0, mem.mem_data[39:8]};
              push_type_s = TY_F32;
              pc_step_s   = 4'd5;
            end else begin
              push_val_s  = mem.mem_data[71:8];
              push_type_s = TY_F64;
              pc_step_s   = 4'd9;
            end
          end
        end
        8'h6A, 8'h6B, 8'h7C, 8'h7D: begin
          if (op64_s && (USE_64B == 32'd0)) begin
            exec_trap_s = TRAP_NO_64B;
          end else if (depth_r < 4'd2) begin
            exec_trap_s = TRAP_UNDERFLOW;
          end else if (type_bad_s) begin
            exec_trap_s = TRAP_TYPE_MISMATCH;
          end else begin
            do_push_s    = 1'b1;
            push_val_s   = arith_s;
            push_type_s  = bin_type_s;
            wr_idx_s     = sec_idx_s;
            depth_next_s = depth_r - 4'd1;
          end
        end
        default: exec_trap_s = TRAP_BAD_OPCODE;
      endcase
    end
  end

  // Control FSM, operand stack and registered result/trap outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_FETCH;
      pc_r           <= '0;
      mem_extra_r    <= 4'd0;
      depth_r        <= 4'd0;
      result_r       <= 64'd0;
      result_type_r  <= TY_I32;
      result_empty_r <= 1'b1;
      trap_r         <= TRAP_NONE;
      for (int i = 0; i < 8; i++) begin
        stack_val_r[i]  <= 64'd0;
        stack_type_r[i] <= TY_I32;
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          state_r     <= ST_EXEC;
          mem_extra_r <= 4'd15;
        end
        ST_EXEC: begin
          if (exec_trap_s != TRAP_NONE) begin
            trap_r      <= exec_trap_s;
            mem_extra_r <= 4'd0;
            state_r     <= ST_HALT;
          end else if (exec_end_s) begin
            mem_extra_r <= 4'd0;
            state_r     <= ST_HALT;
            if (depth_r == 4'd0) begin
              result_r       <= 64'd0;
              result_type_r  <= TY_I32;
              result_empty_r <= 1'b1;
            end else begin
              result_r       <= stack_val_r[top_idx_s];
              result_type_r  <= stack_type_r[top_idx_s];
              result_empty_r <= 1'b0;
            end
          end else begin
            if (do_push_s) begin
              stack_val_r[wr_idx_s]  <= push_val_s;
              stack_type_r[wr_idx_s] <= push_type_s;
            end else begin
              stack_val_r[wr_idx_s]  <= stack_val_r[wr_idx_s];
            end
            depth_r <= depth_next_s;
            pc_r    <= pc_r + PCW'(pc_step_s);
            state_r <= ST_FETCH;
          end
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_wasm_cpu.sv
// Random/directed programs run on two wasm_cpu builds (full, and no-64b/no-fpu), scored against a token-level model.
module tb_wasm_cpu;
  typedef struct {
    logic [7:0]  op;
    logic [63:0] val;
    int          pad;
  } tok_t;

  typedef struct {
    logic [63:0] result;
    logic [1:0]  rtype;
    logic        empty;
    logic [3:0]  trap;
    int          cycles;
  } exp_t;

  localparam logic [70:0] RST_PACK = {64'd0, 2'd0, 1'b1, 4'd0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        err_force = 1'b0;
  logic [63:0] res   [2];
  logic [1:0]  rtype [2];
  logic        remp  [2];
  logic [3:0]  rtrap [2];
  logic [7:0]  rom   [32];
  logic [7:0]  img[$];
  tok_t        prog[$];
  exp_t        q0[$];
  exp_t        q1[$];
  bit          run_go = 1'b0;
  bit          mon_done = 1'b0;
  int          n_total = 0;
  int          n_pass = 0;

  wasm_cpu_if #(.MEM_DEPTH(4)) bus_a ();
  wasm_cpu_if #(.MEM_DEPTH(4)) bus_b ();

  wasm_cpu #(.HAS_FPU(1), .USE_64B(1), .MEM_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .mem(bus_a.master),
    .result(res[0]), .result_type(rtype[0]), .result_empty(remp[0]), .trap(rtrap[0])
  );

  wasm_cpu #(.HAS_FPU(0), .USE_64B(0), .MEM_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .mem(bus_b.master),
    .result(res[1]), .result_type(rtype[1]), .result_empty(remp[1]), .trap(rtrap[1])
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] window(input logic [4:0] base);
    logic [127:0] w;
    logic [4:0]   a;
    for (int k = 0; k < 16; k++) begin
      a = base + 5'(k);
      w[8*k +: 8] = rom[a];
    end
    return w;
  endfunction

  // Registered ROM: window valid one clock after the address.
  always @(posedge clk) begin
    bus_a.mem_data  <= window(bus_a.mem_addr);
    bus_a.mem_error <= err_force;
    bus_b.mem_data  <= window(bus_b.mem_addr);
    bus_b.mem_error <= err_force;
  end

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic logic [70:0] pk(input int k);
    return {res[k], rtype[k], remp[k], rtrap[k]};
  endfunction

  function automatic logic [70:0] pe(input exp_t e);
    return {e.result, e.rtype, e.empty, e.trap};
  endfunction

  task automatic add(input logic [7:0] op, input logic [63:0] val, input int pad);
    tok_t t;
    t.op = op; t.val = val; t.pad = pad;
    prog.push_back(t);
  endtask

  task automatic put_leb(input logic [63:0] v_in, input int minlen);
    logic signed [63:0] v;
    logic [7:0] b;
    int n;
    bit more;
    v = v_in; n = 0; more = 1'b1;
    while (more) begin
      b = {1'b0, v[6:0]};
      v = v >>> 7;
      n++;
      if (((v == 64'sd0 && !b[6]) || (v == -64'sd1 && b[6])) && n >= minlen) more = 1'b0;
      else b[7] = 1'b1;
      img.push_back(b);
    end
  endtask

  task automatic load_rom();
    logic [63:0] v;
    img.delete();
    foreach (prog[i]) begin
      v = prog[i].val;
      img.push_back(prog[i].op);
      case (prog[i].op)
        8'h41, 8'h42: put_leb(v, prog[i].pad);
        8'h43: for (int k = 0; k < 4; k++) img.push_back(v[8*k +: 8]);
        8'h44: for (int k = 0; k < 8; k++) img.push_back(v[8*k +: 8]);
        default: ;
      endcase
    end
    for (int i = 0; i < 32; i++) rom[i] = (i < img.size()) ? img[i] : 8'h0B;
  endtask

  // Reference interpreter over instruction tokens; 2 cycles per executed instruction.
  function automatic exp_t model(input bit use64, input bit fpu, input bit err);
    exp_t e;
    logic [63:0] sv[$];
    logic [1:0]  st[$];
    logic [63:0] a, b, r;
    logic [1:0]  ty;
    logic [7:0]  op;
    bit          i64, sub;
    int          n;
    e.result = 64'd0; e.rtype = 2'd0; e.empty = 1'b1; e.trap = 4'd0; e.cycles = 2;
    if (err) begin
      e.trap = 4'd6;
      return e;
    end
    n = 0;
    foreach (prog[i]) begin
      op = prog[i].op;
      n++;
      e.cycles = 2 * n;
      case (op)
        8'h00: e.trap = 4'd1;
        8'h01: ;
        8'h0B: begin
          if (sv.size() != 0) begin
            e.result = sv[$]; e.rtype = st[$]; e.empty = 1'b0;
          end
          return e;
        end
        8'h1A: begin
          if (sv.size() == 0) e.trap = 4'd3;
          else begin
            void'(sv.pop_back()); void'(st.pop_back());
          end
        end
        8'h41, 8'h42, 8'h43, 8'h44: begin
          if (op == 8'h42 && !use64) e.trap = 4'd5;
          else if ((op == 8'h43 || op == 8'h44) && !fpu) e.trap = 4'd8;
          else if (sv.size() == 8) e.trap = 4'd4;
          else begin
            r = prog[i].val;
            if (op == 8'h41 || op == 8'h43) r = r & 64'h0000_0000_FFFF_FFFF;
            sv.push_back(r);
            st.push_back(2'(op - 8'h41));
          end
        end
        8'h6A, 8'h6B, 8'h7C, 8'h7D: begin
          i64 = (op == 8'h7C) || (op == 8'h7D);
          sub = (op == 8'h6B) || (op == 8'h7D);
          ty  = i64 ? 2'd1 : 2'd0;
          if (i64 && !use64) e.trap = 4'd5;
          else if (sv.size() < 2) e.trap = 4'd3;
          else begin
`ifdef WASM_CPU_TYPECHECK_EN
            if (st[$] != ty || st[$-1] != ty) begin
              e.trap = 4'd7;
              return e;
            end
`endif
            b = sv.pop_back(); void'(st.pop_back());
            a = sv.pop_back(); void'(st.pop_back());
            r = sub ? a - b : a + b;
            if (!i64) r = r % 64'h1_0000_0000;
            sv.push_back(r);
            st.push_back(ty);
          end
        end
        default: e.trap = 4'd2;
      endcase
      if (e.trap != 4'd0) return e;
    end
    return e;
  endfunction

  task automatic gen_random();
    int bytes, r;
    logic [31:0] x;
    logic [7:0] bad [5];
    bad[0] = 8'h02; bad[1] = 8'h20; bad[2] = 8'h6C; bad[3] = 8'hFF; bad[4] = 8'h7E;
    prog.delete();
    bytes = 0;
    while (bytes < 18) begin
      r = $urandom_range(0, 99);
      if (r < 28) begin
        x = ($urandom_range(0, 1) == 0) ? $urandom : (32'($urandom_range(0, 127)) - 32'd64);
        add(8'h41, {{32{x[31]}}, x}, $urandom_range(0, 5)); bytes += 6;
      end else if (r < 42) begin
        add(8'h42, {$urandom, $urandom}, $urandom_range(0, 10)); bytes += 11;
      end else if (r < 48) begin
        add(8'h43, {32'd0, $urandom}, 0); bytes += 5;
      end else if (r < 53) begin
        add(8'h44, {$urandom, $urandom}, 0); bytes += 9;
      end else if (r < 68) begin
        add(($urandom_range(0, 1) == 0) ? 8'h6A : 8'h6B, 64'd0, 0); bytes += 1;
      end else if (r < 80) begin
        add(($urandom_range(0, 1) == 0) ? 8'h7C : 8'h7D, 64'd0, 0); bytes += 1;
      end else if (r < 86) begin
        add(8'h1A, 64'd0, 0); bytes += 1;
      end else if (r < 92) begin
        add(8'h01, 64'd0, 0); bytes += 1;
      end else if (r < 94) begin
        add(8'h00, 64'd0, 0); bytes += 1;
      end else if (r < 96) begin
        add(bad[$urandom_range(0, 4)], 64'd0, 0); bytes += 1;
      end else begin
        add(8'h0B, 64'd0, 0); bytes += 1;
      end
    end
    add(8'h0B, 64'd0, 0);
  endtask

  task automatic run_prog(input bit err, input bit mid);
    @(negedge clk);
    reset = 1'b0;
    load_rom();
    err_force = err;
    q0.push_back(model(1'b1, 1'b1, err));
    q1.push_back(model(1'b0, 1'b0, err));
    repeat (2) @(negedge clk);
    if (mid) begin
      reset = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_a", pk(0), RST_PACK);
      chk("mid_rst_b", pk(1), RST_PACK);
      chk("mid_rst_addr", {66'd0, bus_a.mem_addr}, 71'd0);
      @(negedge clk);
    end
    mon_done = 1'b0;
    reset = 1'b1;
    run_go = 1'b1;
    for (int i = 0; i < 400 && !mon_done; i++) @(negedge clk);
    if (!mon_done) begin
      n_total++;
      $display("FAIL run_timeout: monitor did not finish within 400 cycles");
    end
  endtask

  // Monitor: pops expected outcomes and checks both DUTs at their halt cycle.
  initial begin
    exp_t ea, eb;
    int last;
    forever begin
      wait (run_go);
      run_go = 1'b0;
      ea = q0.pop_front();
      eb = q1.pop_front();
      last = ((ea.cycles > eb.cycles) ? ea.cycles : eb.cycles) + 3;
      for (int c = 1; c <= last; c++) begin
        @(negedge clk);
        if (c == ea.cycles - 1) chk("pre_halt_a", pk(0), RST_PACK);
        if (c == ea.cycles)     chk("halt_a", pk(0), pe(ea));
        if (c == eb.cycles - 1) chk("pre_halt_b", pk(1), RST_PACK);
        if (c == eb.cycles)     chk("halt_b", pk(1), pe(eb));
      end
      chk("hold_a", pk(0), pe(ea));
      chk("hold_b", pk(1), pe(eb));
      mon_done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'h0B;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_a", pk(0), RST_PACK);
    chk("reset_b", pk(1), RST_PACK);

    prog.delete(); add(8'h42, 64'd3, 0); add(8'h42, 64'd2, 0); add(8'h7D, 64'd0, 0); add(8'h0B, 64'd0, 0);
    run_prog(1'b0, 1'b0);
    prog.delete(); add(8'h41, 64'hFFFF_FFFF_FFFF_FFFF, 0); add(8'h41, 64'd1, 0); add(8'h6A, 64'd0, 0); add(8'h0B, 64'd0, 0);
    run_prog(1'b0, 1'b0);
    prog.delete(); add(8'h0B, 64'd0, 0);
    run_prog(1'b0, 1'b0);
    prog.delete(); add(8'h6A, 64'd0, 0); add(8'h0B, 64'd0, 0);
    run_prog(1'b0, 1'b0);
    prog.delete(); for (int i = 0; i < 9; i++) add(8'h41, 64'd0, 0); add(8'h0B, 64'd0, 0);
    run_prog(1'b0, 1'b0);
    prog.delete(); add(8'h00, 64'd0, 0);
    run_prog(1'b0, 1'b0);
    prog.delete(); add(8'hFF, 64'd0, 0);
    run_prog(1'b0, 1'b0);
    prog.delete(); add(8'h41, 64'd5, 0); add(8'h0B, 64'd0, 0);
    run_prog(1'b1, 1'b0);
    prog.delete(); add(8'h44, 64'h0123_4567_89AB_CDEF, 0); add(8'h43, 64'h0000_0000_3F80_0000, 0); add(8'h0B, 64'd0, 0);
    run_prog(1'b0, 1'b0);
    prog.delete(); add(8'h41, 64'hFFFF_FFFF_FFFF_FFFF, 5); add(8'h42, 64'd0, 10); add(8'h1A, 64'd0, 0); add(8'h0B, 64'd0, 0);
    run_prog(1'b0, 1'b0);
    prog.delete(); add(8'h42, 64'd3, 0); add(8'h42, 64'd2, 0); add(8'h7D, 64'd0, 0); add(8'h0B, 64'd0, 0);
    run_prog(1'b0, 1'b1);

    repeat (40) begin
      gen_random();
      run_prog(1'b0, 1'b0);
    end
    gen_random();
    run_prog(1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
